// File: rtl/sregister_rx.sv
// rtl/sregister_rx.sv - strobed serial receiver: start, N data bits MSB first, parity, stop
module sregister_rx #(
    parameter int N          = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sin,
    input  logic         bit_en,
    input  logic         ready,
    output logic [N-1:0] q,
    output logic         valid,
    output logic         parity_err,
    output logic         frame_err,
    output logic         overrun,
    output logic         busy
);
    localparam int   CW  = $clog2(N) + 1;
    localparam logic ODD = (PARITY_ODD != 0);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [N-1:0]  shreg;
    logic          perr;
    logic          complete;

    assign complete = bit_en && (state == STOP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            q          <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (!sin) begin
                            state <= DATA;
                            count <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg <= {shreg[N-2:0], sin};
                        count <= count + CW'(1);
                        if (count == CW'(N - 1)) state <= PARITY;
                    end
                    PARITY: begin
                        // Error when the ones-count over data plus parity bit mismatches the selected sense
                        perr  <= (^shreg ^ sin) ^ ODD;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end

            // A completion while an unconsumed word is held drops the new word
            if (complete) begin
                if (!valid || ready) begin
                    q          <= shreg;
                    parity_err <= perr;
                    frame_err  <= !sin;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sregister_rx.sv
// tb/tb_sregister_rx.sv - table-driven, scoreboarded bench for sregister_rx
module tb_sregister_rx;
    localparam int N = 8;

    logic         clk, reset, sin, bit_en, ready;
    logic [N-1:0] q;
    logic         valid, parity_err, frame_err, overrun, busy;

    sregister_rx #(.N(N), .PARITY_ODD(0)) dut (
        .clk(clk), .reset(reset), .sin(sin), .bit_en(bit_en), .ready(ready),
        .q(q), .valid(valid), .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       sbit;
        logic [7:0] eq;
        logic       epe;
        logic       efe;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic       pe;
        logic       fe;
    } exp_t;

    vec_t vecs[9];
    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    logic vprev    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every rising valid must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (valid && !vprev) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_q", q, e.q);
                chk("sb_parity_err", parity_err, e.pe);
                chk("sb_frame_err", frame_err, e.fe);
            end
        end
        vprev <= valid;
    end

    // One strobe clock followed by one idle clock with a random line value
    task automatic strobe(input logic b, input logic r);
        @(negedge clk);
        sin    = b;
        bit_en = 1'b1;
        ready  = r;
        @(negedge clk);
        bit_en = 1'b0;
        ready  = 1'b0;
        sin    = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input logic [7:0] data, input logic pbit, input logic sbit,
                              input logic push, input logic lat, input logic rdy_stop);
        if (push) sbq.push_back('{data, pbit ^ (^data), !sbit});
        strobe(1'b0, 1'b0);
        chk("busy_after_start", busy, 1'b1);
        for (int i = N - 1; i >= 0; i--) strobe(data[i], 1'b0);
        strobe(pbit, 1'b0);
        if (lat) chk("valid_before_stop", valid, 1'b0);
        chk("busy_before_stop", busy, 1'b1);
        strobe(sbit, rdy_stop);
        if (lat) chk("valid_on_11th_strobe", valid, 1'b1);
        chk("busy_after_stop", busy, 1'b0);
    endtask

    task automatic consume();
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h99, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0};
        vecs[1] = '{8'h99, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[3] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[4] = '{8'h0F, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1};
        vecs[7] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};

        sin = 1'b1; bit_en = 1'b0; ready = 1'b0; reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_q", q, 8'h00);
        chk("reset_valid", valid, 1'b0);
        chk("reset_perr", parity_err, 1'b0);
        chk("reset_ferr", frame_err, 1'b0);
        chk("reset_overrun", overrun, 1'b0);
        chk("reset_busy", busy, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].data, vecs[i].pbit, vecs[i].sbit, 1'b1, 1'b1, 1'b0);
            chk("vec_q", q, vecs[i].eq);
            chk("vec_perr", parity_err, vecs[i].epe);
            chk("vec_ferr", frame_err, vecs[i].efe);
            consume();
            chk("vec_consumed", valid, 1'b0);
            chk("vec_q_hold", q, vecs[i].eq);
            chk("vec_overrun", overrun, 1'b0);
        end

        // Overrun: second word dropped while first unconsumed
        do_reset();
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ovr_q", q, 8'hA5);
        chk("ovr_valid", valid, 1'b1);
        chk("ovr_flag", overrun, 1'b1);
        consume();
        chk("ovr_sticky", overrun, 1'b1);
        chk("ovr_consumed", valid, 1'b0);
        chk("ovr_q_hold", q, 8'hA5);

        // Ready on the completion edge replaces the held word without overrun
        do_reset();
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rdy_q", q, 8'h0F);
        chk("rdy_valid", valid, 1'b1);
        chk("rdy_overrun", overrun, 1'b0);
        chk("rdy_perr", parity_err, 1'b0);
        consume();
        chk("rdy_consumed", valid, 1'b0);

        // Reset mid-frame discards the partial word
        strobe(1'b0, 1'b0);
        for (int i = 7; i >= 4; i--) strobe(1'(8'h3C >> i), 1'b0);
        chk("mid_busy", busy, 1'b1);
        do_reset();
        chk("mid_q_cleared", q, 8'h00);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("mid_q", q, 8'h3C);
        chk("mid_perr", parity_err, 1'b0);
        chk("mid_ferr", frame_err, 1'b0);
        consume();

        // Idle line stays idle
        for (int i = 0; i < 20; i++) begin
            strobe(1'b1, 1'b0);
            chk("idle_busy", busy, 1'b0);
            chk("idle_valid", valid, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sin = 1'(i);
        end
        chk("noen_busy", busy, 1'b0);
        strobe(1'b1, 1'b0);
        chk("noen_busy2", busy, 1'b0);

        repeat (4) @(negedge clk);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sregister_rx.md
SREGISTER_RX -- requirements
Module: sregister_rx

Interface
REQ-001 Parameter N, default 8, data word width in bits (N >= 2).
REQ-002 Parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sin  input  1  serial line; idles high.
REQ-006 bit_en  input  1  bit-period strobe; sin is sampled only on edges where bit_en=1.
REQ-007 ready  input  1  consumer accepts q when ready=1 and valid=1.
REQ-008 q  output  N  last received word.
REQ-009 valid  output  1  q holds an unconsumed word.
REQ-010 parity_err  output  1  parity status of the word in q.
REQ-011 frame_err  output  1  stop-bit status of the word in q.
REQ-012 overrun  output  1  sticky flag: a completed word was dropped.
REQ-013 busy  output  1  a frame is in progress (state != IDLE).

Function
REQ-014 Frame format SHALL be: start bit 0, then N data bits MSB first, then 1 parity bit, then 1 stop bit 1.
REQ-015 The FSM SHALL have states IDLE, DATA, PARITY and STOP; on edges where bit_en=0, state, bit counter and shift register SHALL hold.
REQ-016 In IDLE with bit_en=1: sin=0 -> DATA with bit count cleared; sin=1 -> remain in IDLE.
REQ-017 In DATA, each strobe SHALL shift: shreg <= {shreg[N-2:0], sin}, count += 1; the strobe that captures the Nth bit -> PARITY.
REQ-018 In PARITY, the strobe SHALL latch perr = (^shreg ^ sin) != PARITY_ODD, then -> STOP.
REQ-019 In STOP, the strobe SHALL complete the frame and return to IDLE; ferr = (sin == 0).
REQ-020 On completion with valid=0, or with valid=1 and ready=1 on the same edge: q <= shreg, parity_err <= perr, frame_err <= ferr, valid <= 1.
REQ-021 On completion with valid=1 and ready=0: q, parity_err, frame_err and valid SHALL hold; the new word is dropped; overrun <= 1.
REQ-022 Without completion, valid=1 and ready=1 at an edge SHALL clear valid on that edge; q and the error flags SHALL hold their values.
REQ-023 q, parity_err and frame_err SHALL change only on a completion edge per REQ-020.
REQ-024 overrun SHALL remain 1 until reset.
REQ-025 Latency: valid SHALL rise on the edge of the (N+3)th strobe counted from the start-bit strobe inclusive.
REQ-026 busy SHALL be 1 in DATA, PARITY and STOP, and 0 in IDLE.
REQ-027 A parity or frame error SHALL NOT suppress delivery; the word is delivered with its flags.

Reset
REQ-028 On reset=1 (async): state=IDLE, count=0, shreg=0, q=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
REQ-029 Reset mid-frame SHALL discard the partial frame; the first strobe after release SHALL be evaluated as IDLE per REQ-016.

Verification (N=8, PARITY_ODD=0, bit_en one clock in every 2)
REQ-030 Send start, 1001_1001, parity 0, stop 1, with ready=0 -> q=8'h99, valid=1, parity_err=0, frame_err=0, valid rising on the 11th strobe.
REQ-031 Send the same data with parity bit 1 -> q=8'h99, parity_err=1. Send 8'h3C with parity 0 and stop 0 -> q=8'h3C, frame_err=1.
REQ-032 Send two frames, 8'hA5 then 8'h0F, with ready=0 -> q=8'hA5, overrun=1 (still 1 after ready is pulsed); raise ready on the second frame's completion edge instead -> q=8'h0F, valid stays 1, overrun=0.
REQ-033 Assert reset after 4 data bits, then send 8'h3C correctly -> busy=0 and valid=0 during reset, then q=8'h3C, valid=1, no error flags.
REQ-034 Hold sin=1 for 20 strobes -> busy=0 and valid=0 throughout; toggle sin with bit_en=0 -> no state change.
